// File: rtl/o3_resp_checker.sv
// o3_resp_checker: exhaustive-vector response checker for the o3 block.
// Walks every input vector in ascending order, samples the block's outputs
// after a settle delay and compares them against an expected table that is
// latched when the run starts.
//
// Ports:
//   clk, rst         rising-edge clock, synchronous active-high reset
//   start            run request, accepted only while idle
//   exp_tbl          expected responses, entry v at [v*N_OUT +: N_OUT]
//   resp_in          checked block outputs {y,z}
//   vec_out          vector driven to the checked block {a,b,c,d}
//   busy, done       run in progress / one-cycle end-of-run pulse
//   pass, err_cnt    result of the current or last run
//   first_err_vec    index of the first mismatching vector
//   first_err_valid  at least one mismatch recorded
//
// Build option: O3_CHK_STOP_ON_ERR_EN ends the run at the first mismatch.
module o3_resp_checker #(
    parameter int N_IN   = 4,
    parameter int N_OUT  = 2,
    parameter int SETTLE = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [(2**N_IN)*N_OUT-1:0]  exp_tbl,
    input  logic [N_OUT-1:0]            resp_in,
    output logic [N_IN-1:0]             vec_out,
    output logic                        busy,
    output logic                        done,
    output logic                        pass,
    output logic [N_IN:0]               err_cnt,
    output logic [N_IN-1:0]             first_err_vec,
    output logic                        first_err_valid
);

    localparam int TBL_W = (2**N_IN)*N_OUT;
    localparam logic [3:0] WAIT_LD = (SETTLE > 0) ? 4'(SETTLE-1) : 4'd0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_WAIT,
        S_SAMPLE,
        S_DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [TBL_W-1:0] tbl_q;
    logic [N_IN-1:0]  idx;
    logic [3:0]       wcnt;
    logic             mismatch;
    logic             last_vec;
    logic             stop;

    assign mismatch = resp_in != tbl_q[idx*N_OUT +: N_OUT];
    assign last_vec = &idx;

`ifdef O3_CHK_STOP_ON_ERR_EN
    assign stop = last_vec | mismatch;
`else
    assign stop = last_vec;
`endif

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:   if (start) state_nxt = S_DRIVE;
            S_DRIVE:  state_nxt = (SETTLE > 0) ? S_WAIT : S_SAMPLE;
            S_WAIT:   if (wcnt == 4'd0) state_nxt = S_SAMPLE;
            S_SAMPLE: state_nxt = stop ? S_DONE : S_DRIVE;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tbl_q           <= '0;
            idx             <= '0;
            wcnt            <= '0;
            vec_out         <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            err_cnt         <= '0;
            first_err_vec   <= '0;
            first_err_valid <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        tbl_q           <= exp_tbl;
                        idx             <= '0;
                        busy            <= 1'b1;
                        pass            <= 1'b0;
                        err_cnt         <= '0;
                        first_err_vec   <= '0;
                        first_err_valid <= 1'b0;
                    end
                end
                S_DRIVE: begin
                    vec_out <= idx;
                    wcnt    <= WAIT_LD;
                end
                S_WAIT: begin
                    if (wcnt != 4'd0) wcnt <= wcnt - 4'd1;
                end
                S_SAMPLE: begin
                    if (mismatch) begin
                        err_cnt <= err_cnt + 1'b1;
                        if (!first_err_valid) begin
                            first_err_vec   <= idx;
                            first_err_valid <= 1'b1;
                        end
                    end
                    if (stop) begin
                        // Fold in this sample so pass is valid alongside done.
                        busy <= 1'b0;
                        done <= 1'b1;
                        pass <= !mismatch && (err_cnt == '0);
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                S_DONE: begin
                    done <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/o3_resp_checker.md
Name: o3_resp_checker

Overview:
- Synthesizable response checker for the 4-input/2-output o3 block: the capture-and-compare end of o3's exhaustive vector stimulus.
- On `start`, drives all 2^N_IN input vectors to the DUT in ascending order and samples the DUT outputs after a settle delay.
- Compares each response against a latched expected truth table and reports pass/fail, error count and first failing vector.
- Sits beside o3 in the self-test wrapper; bench and board use it to check o3 without a waveform viewer.

Parameters:
- N_IN, 4, number of DUT inputs; vector bits ordered {a,b,c,d}, a = MSB.
- N_OUT, 2, number of DUT outputs; resp_in[1] = y, resp_in[0] = z.
- SETTLE, 1, extra wait cycles between driving a vector and sampling; legal range 0..15.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  run request; accepted only in IDLE.
- exp_tbl  in  (2^N_IN)*N_OUT  expected responses; entry v is exp_tbl[v*N_OUT +: N_OUT].
- resp_in  in  N_OUT  DUT outputs {y,z}.
- vec_out  out  N_IN  vector driven to DUT {a,b,c,d}.
- busy  out  1  high from start acceptance until DONE is entered.
- done  out  1  one-cycle pulse at end of run.
- pass  out  1  1 when the last completed run had err_cnt==0.
- err_cnt  out  N_IN+1  mismatch count of current/last run.
- first_err_vec  out  N_IN  vector index of the first mismatch.
- first_err_valid  out  1  at least one mismatch has been recorded.

Behaviour:
- Reset values, applied at the next edge with rst high, including mid-run: state=IDLE; vec_out, busy, done, pass, err_cnt, first_err_vec and first_err_valid all 0.
- FSM states: IDLE, DRIVE, WAIT, SAMPLE, DONE.
- IDLE:
  - start=1 at edge 0 → DRIVE.
  - At that edge: latch exp_tbl into internal register; clear err_cnt, first_err_valid, first_err_vec and pass; set idx=0; busy=1.
- DRIVE: vec_out <= idx (registered, held through WAIT/SAMPLE) → WAIT if SETTLE>0, else SAMPLE.
- WAIT: SETTLE cycles via down-counter → SAMPLE.
- SAMPLE: at exit edge compare resp_in against latched entry idx.
  - On mismatch: err_cnt++.
  - If first_err_valid=0: first_err_vec<=idx and first_err_valid<=1.
  - If idx==2^N_IN-1 → DONE; else idx++ → DRIVE.
- Timing: vector v enters DRIVE at edge v*(SETTLE+2); DONE is entered at edge 2^N_IN*(SETTLE+2). With defaults, that is edge 48.
- DONE: done=1 and busy=0 for exactly one cycle; pass <= (err_cnt==0), including the final SAMPLE's result → IDLE.
- Held values: pass, err_cnt, first_err_* and vec_out (last vector) hold until the next accepted start or rst.
- exp_tbl changes during a run are ignored; only the value latched at start is used.
- start while busy or in DONE is ignored; no queuing.
- err_cnt max is 2^N_IN, so it fits N_IN+1 bits and never wraps.
- Simultaneous rst and start: rst wins.

Optional Feature:
- Macro: O3_CHK_STOP_ON_ERR_EN.
- Defined: a mismatch in SAMPLE goes directly to DONE. err_cnt ends at 1, pass=0, and done arrives at edge (v+1)*(SETTLE+2), where v is the failing vector.
- Undefined: the full sweep always completes, and all mismatches are counted.

Test Plan:
- Reset: hold rst 3 cycles with start=1 → all outputs 0, state stays IDLE, vec_out=0.
- Matching table (bench DUT model equals exp_tbl), SETTLE=1, start at edge 0:
  - vec_out steps 0..15, each held 3 cycles.
  - done pulses one cycle after edge 48.
  - pass=1, err_cnt=0, first_err_valid=0.
- Entry 9 flipped to 2'b11 against DUT 2'b00 → err_cnt=1, first_err_vec=9, first_err_valid=1, pass=0.
- All 16 entries inverted → err_cnt=16 (5'b10000), first_err_vec=0, pass=0.
- Mid-run interference:
  - start re-pulsed at edge 10 → no effect; done still at edge 48.
  - In a second run, rst at edge 20 → IDLE next cycle, vec_out=0, busy=0, no done pulse.
- With O3_CHK_STOP_ON_ERR_EN defined, mismatches at vectors 5 and 12 → done after edge 18, err_cnt=1, first_err_vec=5, vec_out=5.
